// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops a FIFO with one-cycle read latency and packs Pack entries per valid/ready output word.
// Optional idle-timeout partial flush is enabled by defining FIFO_RD_PACK_FLUSH_EN.
module fifo_rd_packer #(
  parameter int Data_Width = 8,
  parameter int Pack = 4,
  parameter int Timeout = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rstn,
  input  logic                       empty,
  output logic                       rd_en,
  input  logic [Data_Width-1:0]      fifo_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [Data_Width*Pack-1:0] m_data,
  output logic [Pack-1:0]            m_keep
);
  localparam int CW = $clog2(Pack + 1) + 1;
  localparam logic [CW-1:0] PackC = CW'(Pack);
  logic [Data_Width*Pack-1:0] acc, data_n;
  logic [Pack-1:0] keep_n;
  logic [CW-1:0] cnt, cnt_eff;
  logic inflight, flush, xfer;
  if (Pack < 2 || Timeout < 1) begin : g_bad_param
    $error("fifo_rd_packer: Pack must be >= 2 and Timeout >= 1");
  end
`ifdef FIFO_RD_PACK_FLUSH_EN
  localparam int TW = $clog2(Timeout + 1);
  localparam logic [TW-1:0] TimeoutC = TW'(Timeout);
  logic [TW-1:0] timer;
  assign flush = (timer == TimeoutC) && (cnt != '0);
  // idle timer: counts dry cycles holding a partial word, saturating at the timeout
  always_ff @(posedge rd_clk or negedge rd_rstn)
    if (!rd_rstn) timer <= '0;
    else if (rd_en || xfer) timer <= '0;
    else if (cnt != '0 && !inflight && empty && timer != TimeoutC) timer <= timer + 1'b1;
`else
  assign flush = 1'b0;
`endif
  assign xfer = (cnt == PackC || flush) && (!m_valid || m_ready);
  assign cnt_eff = xfer ? '0 : cnt;
  assign rd_en = rd_rstn && !empty && ((cnt_eff + CW'(inflight)) < PackC);
  // outgoing word: keep marks filled lanes, unfilled lanes forced to zero
  always_comb begin
    keep_n = '0;
    data_n = '0;
    for (int i = 0; i < Pack; i++) begin
      keep_n[i] = CW'(i) < cnt;
      data_n[i*Data_Width +: Data_Width] = keep_n[i] ? acc[i*Data_Width +: Data_Width] : '0;
    end
  end
  // accumulator: the previous cycle's pop lands in the next free lane
  always_ff @(posedge rd_clk or negedge rd_rstn)
    if (!rd_rstn) begin
      acc <= '0;
      cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      cnt <= cnt_eff + CW'(inflight);
      if (inflight) acc[int'(cnt_eff)*Data_Width +: Data_Width] <= fifo_data;
    end
  // output register: load on transfer, hold while stalled, drop after accept
  always_ff @(posedge rd_clk or negedge rd_rstn)
    if (!rd_rstn) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_keep <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data <= data_n;
      m_keep <= keep_n;
    end else if (m_ready) m_valid <= 1'b0;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scenario table, corner sequences and random traffic against a popped-entry scoreboard.
module tb_fifo_rd_packer;
  localparam int DW = 8, PK = 4, TO = 16;
  logic rd_clk = 1'b0, rd_rstn = 1'b0, empty = 1'b1, m_ready = 1'b0;
  logic rd_en, m_valid;
  logic [DW-1:0] fifo_data = '0;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0] m_keep;

  fifo_rd_packer #(.Data_Width(DW), .Pack(PK), .Timeout(TO)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .empty(empty), .rd_en(rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int n; logic [7:0] base; bit stall; bit toggle;
    int exp_words; int exp_pops; logic [31:0] exp_first; int exp_stall_pops;
  } vec_t;
  vec_t vecs[4];

  logic [7:0] fifo_q[$], exp_q[$];
  logic [7:0] pend_d;
  bit pend, prev_stall, any_valid, done;
  logic [31:0] prev_data, first_word, last_word;
  logic [3:0] prev_keep, last_keep;
  int pops, words, cyc, last_pop;
  int checks = 0, failures = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // an accepted word must carry the oldest popped entries, lane 0 first, contiguous keep
  task automatic score();
    int n;
    logic [31:0] exp_d;
    logic [3:0] exp_k;
    n = $countones(m_keep);
`ifdef FIFO_RD_PACK_FLUSH_EN
    exp_k = (n == 0) ? 4'b0001 : 4'((1 << n) - 1);
`else
    exp_k = 4'hF;
`endif
    exp_d = '0;
    for (int i = 0; i < PK; i++)
      if (exp_k[i]) exp_d[i*8 +: 8] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk(m_keep === exp_k, "word_keep", 32'(m_keep), 32'(exp_k));
    chk(m_data === exp_d, "word_data", m_data, exp_d);
    words++;
    if (words == 1) first_word = m_data;
    last_word = m_data;
    last_keep = m_keep;
  endtask

  // one clock: model FIFO read latency, drive inputs at negedge, observe before posedge
  task automatic cycle(input bit ready, input bit gate);
    @(negedge rd_clk);
    fifo_data = pend ? pend_d : 8'($urandom);
    pend = 0;
    m_ready = ready;
    empty = gate || fifo_q.size() == 0;
    #1;
    cyc++;
    if (m_valid) any_valid = 1;
    if (prev_stall) begin
      chk(m_valid === 1'b1, "hold_valid", 32'(m_valid), 1);
      chk(m_data === prev_data, "hold_data", m_data, prev_data);
      chk(m_keep === prev_keep, "hold_keep", 32'(m_keep), 32'(prev_keep));
    end
    if (m_valid && m_ready) score();
    if (rd_en) begin
      chk(!empty, "pop_when_empty", 32'(empty), 0);
      if (!empty) begin
        pend_d = fifo_q.pop_front();
        pend = 1;
        exp_q.push_back(pend_d);
        pops++;
        last_pop = cyc;
        chk(exp_q.size() <= 2 * PK, "overpop", exp_q.size(), 2 * PK);
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data = m_data;
    prev_keep = m_keep;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_pops;
    words = 0; pops = 0; stall_pops = -1; done = 0;
    for (int i = 0; i < v.n; i++) fifo_q.push_back(8'(v.base + 8'(i)));
    for (int c = 0; c < 400 && !done; c++) begin
      cycle(!v.stall || c >= 40, v.toggle && c[0]);
      if (c == 39) stall_pops = pops;
      done = fifo_q.size() == 0 && exp_q.size() == 0 && !pend;
    end
    chk(done, "vec_drain", 32'(done), 1);
    chk(words == v.exp_words, "vec_words", words, v.exp_words);
    chk(pops == v.exp_pops, "vec_pops", pops, v.exp_pops);
    chk(first_word == v.exp_first, "vec_first_word", first_word, v.exp_first);
    if (v.stall) chk(stall_pops == v.exp_stall_pops, "stall_pops", stall_pops, v.exp_stall_pops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8,  8'h01, 1'b0, 1'b0, 2, 8,  32'h04030201, 0};
    vecs[1] = '{12, 8'h10, 1'b0, 1'b1, 3, 12, 32'h13121110, 0};
    vecs[2] = '{12, 8'h20, 1'b1, 1'b0, 3, 12, 32'h23222120, 8};
    vecs[3] = '{16, 8'h40, 1'b0, 1'b1, 4, 16, 32'h43424140, 0};
    repeat (3) @(negedge rd_clk);
    chk(rd_en === 1'b0, "reset_rd_en", 32'(rd_en), 0);
    chk(m_valid === 1'b0, "reset_m_valid", 32'(m_valid), 0);
    chk(m_data === '0, "reset_m_data", m_data, 0);
    chk(m_keep === '0, "reset_m_keep", 32'(m_keep), 0);
    rd_rstn = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);

    // partial word: three entries then a dry FIFO
    words = 0; any_valid = 0;
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2); fifo_q.push_back(8'hA3);
`ifdef FIFO_RD_PACK_FLUSH_EN
    for (int c = 0; c < 60 && words == 0; c++) cycle(1'b1, 1'b0);
    chk(words == 1, "flush_words", words, 1);
    chk(last_word == 32'h00A3A2A1, "flush_data", last_word, 32'h00A3A2A1);
    chk(last_keep == 4'b0111, "flush_keep", 32'(last_keep), 32'h7);
    chk(cyc - last_pop == TO + 3, "flush_delay", cyc - last_pop, TO + 3);
`else
    repeat (60) cycle(1'b1, 1'b0);
    chk(!any_valid, "partial_held", 32'(any_valid), 0);
    fifo_q.push_back(8'hA4);
    for (int c = 0; c < 20 && words == 0; c++) cycle(1'b1, 1'b0);
    chk(words == 1, "partial_words", words, 1);
    chk(last_word == 32'hA4A3A2A1, "partial_data", last_word, 32'hA4A3A2A1);
    chk(last_keep == 4'hF, "partial_keep", 32'(last_keep), 32'hF);
`endif

    // asynchronous reset with a held word and a partial accumulator
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'hB0 + 8'(i)));
    repeat (12) cycle(1'b0, 1'b0);
    chk(m_valid === 1'b1, "pre_reset_valid", 32'(m_valid), 1);
    @(negedge rd_clk);
    #2 rd_rstn = 1'b0;
    #1;
    chk(rd_en === 1'b0, "midreset_rd_en", 32'(rd_en), 0);
    chk(m_valid === 1'b0, "midreset_m_valid", 32'(m_valid), 0);
    chk(m_data === '0, "midreset_m_data", m_data, 0);
    chk(m_keep === '0, "midreset_m_keep", 32'(m_keep), 0);
    fifo_q.delete(); exp_q.delete(); pend = 0; prev_stall = 0;
    repeat (2) @(negedge rd_clk);
    rd_rstn = 1'b1;
    words = 0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'hD1 + 8'(i)));
    for (int c = 0; c < 30 && words == 0; c++) cycle(1'b1, 1'b0);
    chk(words == 1, "post_reset_words", words, 1);
    chk(first_word == 32'hD4D3D2D1, "post_reset_lane0", first_word, 32'hD4D3D2D1);
    chk(last_keep == 4'hF, "post_reset_keep", 32'(last_keep), 32'hF);

    // random traffic with random FIFO dry spells and downstream stalls
    words = 0; done = 0;
    for (int i = 0; i < 200; i++) fifo_q.push_back(8'($urandom));
    for (int c = 0; c < 4000 && !done; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      done = fifo_q.size() == 0 && exp_q.size() == 0 && !pend;
    end
    chk(done, "random_drain", 32'(done), 1);
`ifdef FIFO_RD_PACK_FLUSH_EN
    chk(words >= 50, "random_words", words, 50);
`else
    chk(words == 50, "random_words", words, 50);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
